// File: rtl/skid_buffer.sv
// skid_buffer: 2-entry elastic stage (main + skid register) with all outputs registered.
module skid_buffer #(
  parameter int DW = 8,
  parameter type dw_t = logic [DW-1:0]
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  input  dw_t        in_data,
  output logic       in_ready,
  output logic       out_valid,
  output dw_t        out_data,
  input  logic       out_ready,
  output logic [1:0] count
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
  logic [1:0] state_q, state_d, count_q, count_d;
  logic       in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  dw_t        main_q, main_d, skid_q, skid_d;
  logic       in_fire, out_fire;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign count     = count_q;
  assign in_fire   = in_valid && in_ready_q;
  assign out_fire  = out_valid_q && out_ready;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        main_d  = in_fire ? in_data : main_q;
        state_d = in_fire ? BUSY : EMPTY;
      end
      BUSY: begin
        main_d  = (in_fire && out_fire) ? in_data : main_q;
        skid_d  = (in_fire && !out_fire) ? in_data : skid_q;
        state_d = (in_fire && !out_fire) ? FULL : (out_fire && !in_fire) ? EMPTY : BUSY;
      end
      FULL: begin
        main_d  = out_fire ? skid_q : main_q;
        state_d = out_fire ? BUSY : FULL;
      end
      default: state_d = EMPTY;
    endcase
    state_d     = flush ? EMPTY : state_d;
    count_d     = state_d;
    out_valid_d = state_d != EMPTY;
    in_ready_d  = state_d != FULL;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      count_q     <= 2'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end
  // payload registers carry no reset; out_data is don't-care while out_valid is low
  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end
endmodule

// File: doc/skid_buffer.md
SKID_BUFFER -- requirements
Module: skid_buffer

Interface
REQ-001 Parameter DW, default 8: payload width in bits.
REQ-002 Parameter dw_t, default logic [DW-1:0]: payload type.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 flush  input  1  synchronous clear of all buffered data.
REQ-007 in_valid  input  1  upstream has a beat on in_data.
REQ-008 in_data  input  dw_t  upstream payload.
REQ-009 in_ready  output  1  buffer accepts a beat this cycle.
REQ-010 out_valid  output  1  out_data holds a valid beat.
REQ-011 out_data  output  dw_t  payload to the downstream stage, e.g. a delay chain's input.
REQ-012 out_ready  input  1  downstream accepts a beat this cycle; may also drive a delay chain's en.
REQ-013 count  output  2  number of beats held, 0..2.

Function
REQ-014 The block shall be a 2-entry elastic stage with a main register and a skid register that breaks the combinational ready path: in_ready, out_valid, out_data and count shall all be driven directly from flops.
REQ-015 Input fire shall be in_valid && in_ready; output fire shall be out_valid && out_ready.
REQ-016 The state machine shall have three states: EMPTY (count 0, out_valid 0, in_ready 1), BUSY (count 1, out_valid 1, in_ready 1), FULL (count 2, out_valid 1, in_ready 0).
REQ-017 EMPTY: on input fire, main <= in_data and the next state shall be BUSY; otherwise EMPTY.
REQ-018 BUSY, input fire and output fire together: main <= in_data, stay BUSY (full-throughput streaming).
REQ-019 BUSY, input fire without output fire: skid <= in_data, go to FULL; main unchanged.
REQ-020 BUSY, output fire without input fire: go to EMPTY.
REQ-021 BUSY, neither fire: hold all state.
REQ-022 FULL: on output fire, main <= skid and go to BUSY; otherwise hold. An input fire is impossible in FULL because in_ready=0.
REQ-023 Latency: a beat accepted at edge N shall be visible on out_data with out_valid=1 after edge N when the buffer was EMPTY, i.e. 1 cycle.
REQ-024 Ordering shall be strict FIFO; no beat shall be duplicated or dropped except by flush or rst.
REQ-025 out_data shall remain stable while out_valid=1 and out_ready=0.
REQ-026 flush=1 at an edge shall force EMPTY regardless of handshakes in that cycle; the beats accepted or presented in that cycle shall be discarded.
REQ-027 Sustained in_valid=1 with out_ready=1 shall give one beat per cycle with in_ready held at 1.
REQ-028 out_data when out_valid=0 is don't-care; data registers need no reset.

Reset
REQ-029 rst=1 at a rising edge shall force EMPTY: out_valid=0, in_ready=1, count=0.
REQ-030 rst shall take priority over flush and over all handshakes, including reset asserted mid-stream while FULL.
REQ-031 In the first cycle after rst deasserts, the block shall accept a beat.

Verification
REQ-032 Apply rst, then send A=0x11: out_valid=1 and out_data=0x11 one cycle later, count=1.
REQ-033 With out_ready=0, send 0x11 then 0x22: count=2, in_ready=0, out_data=0x11 stable; raise out_ready: outputs 0x11 then 0x22 in order, in_ready returns to 1 one cycle after the first output fire.
REQ-034 Stream 0x01..0x10 with in_valid=1 and out_ready=1 held: 16 beats out in order on consecutive cycles, in_ready=1 throughout.
REQ-035 Randomized in_valid/out_ready over 1000 beats against a reference queue: no loss, duplication or reorder, and count always matches the queue depth.
REQ-036 In FULL, assert flush together with out_ready=1: next cycle count=0, out_valid=0, in_ready=1, and no further beats emerge.
REQ-037 In FULL, assert rst together with flush and in_valid: next cycle EMPTY with count=0; a beat sent the following cycle is accepted.
